eth_idma_cfg_seq: RTL and testbench

Hardware configuration sequencer for the Ethernet iDMA (`eth_idma_wrap`). It replaces software/testbench register pokes with an FSM. It accepts one transfer descriptor per handshake and drives the iDMA register-interface port through the full write sequence: MAC, addresses, length, protocols and request pulse. It then polls for completion and acknowledges the response. It sits between a requester (CVA6 peripheral, safety island, or bench driver) and the `reg_req_i`/`reg_rsp_o` port of the Ethernet island.

---
 rtl/eth_idma_cfg_seq_pkg.sv | 77 +++++++
 rtl/eth_idma_reg_pkg.sv | 18 +
 rtl/eth_idma_cfg_step_rom.sv | 38 +++
 rtl/eth_idma_cfg_seq.sv | 205 ++++++++++++++++++++
 tb/tb_eth_idma_cfg_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_idma_cfg_seq_pkg.sv
// Shared types for the Ethernet iDMA configuration sequencer.
package eth_idma_cfg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_POLL  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  typedef logic [3:0] step_t;

  // Step indices with a special role in the sequence; step 11 is the poll read.
  localparam step_t StepMacLo   = 4'd0;
  localparam step_t StepSrcAddr = 4'd2;
  localparam step_t StepReqClr  = 4'd8;
  localparam step_t StepRspSet  = 4'd9;
  localparam step_t StepRspClr  = 4'd10;
  localparam step_t StepPoll    = 4'd11;

  localparam logic [2:0] ProtoAxi = 3'd0;
  localparam logic [2:0] ProtoEth = 3'd5;

  typedef enum logic [3:0] {
    WSEL_ZERO   = 4'd0,
    WSEL_ONE    = 4'd1,
    WSEL_MACLO  = 4'd2,
    WSEL_MACHI  = 4'd3,
    WSEL_SRC    = 4'd4,
    WSEL_DST    = 4'd5,
    WSEL_LEN    = 4'd6,
    WSEL_SPROTO = 4'd7,
    WSEL_DPROTO = 4'd8
  } wsel_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [2:0]  sproto;
    logic [2:0]  dproto;
  } desc_t;

  // Pick the write payload for a step from the descriptor.
  function automatic logic [31:0] sel_wdata(input wsel_e sel, input desc_t d);
    logic [31:0] w;
    case (sel)
      WSEL_ONE:    w = 32'h0000_0001;
      WSEL_MACLO:  w = d.mac[31:0];
      WSEL_MACHI:  w = {16'h0000, d.mac[47:32]};
      WSEL_SRC:    w = d.src;
      WSEL_DST:    w = d.dst;
      WSEL_LEN:    w = d.len;
      WSEL_SPROTO: w = {29'h0, d.sproto};
      WSEL_DPROTO: w = {29'h0, d.dproto};
      default:     w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/eth_idma_reg_pkg.sv
// Ethernet iDMA register map: byte offsets of the register-interface port.
package eth_idma_reg_pkg;

  parameter int BlockAw = 8;

  parameter logic [BlockAw-1:0] ETH_IDMA_MACLO_ADDR_OFFSET        = 8'h00;
  parameter logic [BlockAw-1:0] ETH_IDMA_MACHI_MDIO_OFFSET        = 8'h04;
  parameter logic [BlockAw-1:0] ETH_IDMA_SRC_ADDR_OFFSET          = 8'h08;
  parameter logic [BlockAw-1:0] ETH_IDMA_DST_ADDR_OFFSET          = 8'h0c;
  parameter logic [BlockAw-1:0] ETH_IDMA_LENGTH_OFFSET            = 8'h10;
  parameter logic [BlockAw-1:0] ETH_IDMA_SRC_PROTOCOL_OFFSET      = 8'h14;
  parameter logic [BlockAw-1:0] ETH_IDMA_DST_PROTOCOL_OFFSET      = 8'h18;
  parameter logic [BlockAw-1:0] ETH_IDMA_REQ_VALID_OFFSET         = 8'h1c;
  parameter logic [BlockAw-1:0] ETH_IDMA_REQ_READY_OFFSET         = 8'h20;
  parameter logic [BlockAw-1:0] ETH_IDMA_RSP_READY_OFFSET         = 8'h24;
  parameter logic [BlockAw-1:0] ETH_IDMA_RSP_VALID_OFFSET         = 8'h28;

endpackage

// File: rtl/eth_idma_cfg_step_rom.sv
// Step decode: maps a sequence step to register offset, payload select and direction.
module eth_idma_cfg_step_rom
  import eth_idma_cfg_seq_pkg::*;
  import eth_idma_reg_pkg::*;
(
  input  step_t              step_i,
  output logic [BlockAw-1:0] offset_o,
  output wsel_e              wsel_o,
  output logic               write_o
);

  // Pure table lookup; unknown steps fall back to a harmless status read.
  always_comb begin
    offset_o = ETH_IDMA_RSP_VALID_OFFSET;
    wsel_o   = WSEL_ZERO;
    write_o  = 1'b0;
    case (step_i)
      4'd0:  begin offset_o = ETH_IDMA_MACLO_ADDR_OFFSET;   wsel_o = WSEL_MACLO;  write_o = 1'b1; end
      4'd1:  begin offset_o = ETH_IDMA_MACHI_MDIO_OFFSET;   wsel_o = WSEL_MACHI;  write_o = 1'b1; end
      4'd2:  begin offset_o = ETH_IDMA_SRC_ADDR_OFFSET;     wsel_o = WSEL_SRC;    write_o = 1'b1; end
      4'd3:  begin offset_o = ETH_IDMA_DST_ADDR_OFFSET;     wsel_o = WSEL_DST;    write_o = 1'b1; end
      4'd4:  begin offset_o = ETH_IDMA_LENGTH_OFFSET;       wsel_o = WSEL_LEN;    write_o = 1'b1; end
      4'd5:  begin offset_o = ETH_IDMA_SRC_PROTOCOL_OFFSET; wsel_o = WSEL_SPROTO; write_o = 1'b1; end
      4'd6:  begin offset_o = ETH_IDMA_DST_PROTOCOL_OFFSET; wsel_o = WSEL_DPROTO; write_o = 1'b1; end
      4'd7:  begin offset_o = ETH_IDMA_REQ_VALID_OFFSET;    wsel_o = WSEL_ONE;    write_o = 1'b1; end
      4'd8:  begin offset_o = ETH_IDMA_REQ_VALID_OFFSET;    wsel_o = WSEL_ZERO;   write_o = 1'b1; end
      4'd9:  begin offset_o = ETH_IDMA_RSP_READY_OFFSET;    wsel_o = WSEL_ONE;    write_o = 1'b1; end
      4'd10: begin offset_o = ETH_IDMA_RSP_READY_OFFSET;    wsel_o = WSEL_ZERO;   write_o = 1'b1; end
      4'd11: begin offset_o = ETH_IDMA_RSP_VALID_OFFSET;    wsel_o = WSEL_ZERO;   write_o = 1'b0; end
      default: begin
        offset_o = ETH_IDMA_RSP_VALID_OFFSET;
        wsel_o   = WSEL_ZERO;
        write_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/eth_idma_cfg_seq.sv
// Ethernet iDMA configuration sequencer: takes one descriptor, programs the
// iDMA over its register port, polls for completion and acknowledges it.
module eth_idma_cfg_seq
  import eth_idma_cfg_seq_pkg::*;
  import eth_idma_reg_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned PollTimeout = 32'd1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic        mac_update_i,
  input  logic [47:0] mac_addr_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [31:0] length_i,
  input  logic [2:0]  src_proto_i,
  input  logic [2:0]  dst_proto_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i
);

  localparam int unsigned CntW   = $clog2(PollTimeout + 32'd1);
  localparam logic [CntW-1:0] CntLimit = CntW'(PollTimeout);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  seq_state_e        state_q, state_d;
  step_t             step_q, step_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  desc_t             desc_q, desc_d;
  reg_req_t          req_q, req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  desc_t             desc_in_s;
  desc_t             desc_src_s;
  step_t             nstep_s;
  logic              load_s;
  logic              acc_s;
  logic [CntW-1:0]   cnt_inc_s;
  logic [BlockAw-1:0] rom_offset_s;
  wsel_e             rom_wsel_s;
  logic              rom_write_s;
  logic [30:0]       unused_rdata_s;

  assign desc_in_s = '{mac: mac_addr_i, src: src_addr_i, dst: dst_addr_i,
                       len: length_i, sproto: src_proto_i, dproto: dst_proto_i};

  // At the handshake the fields are not latched yet, so the first access reads the inputs.
  assign desc_src_s = (state_q == ST_IDLE) ? desc_in_s : desc_q;

  assign acc_s          = req_q.valid & reg_rsp_i.ready;
  assign cnt_inc_s      = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign unused_rdata_s = reg_rsp_i.rdata[31:1];

  assign desc_ready_o = (state_q == ST_IDLE);
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign reg_req_o    = req_q;

  eth_idma_cfg_step_rom u_step_rom (
    .step_i   (nstep_s),
    .offset_o (rom_offset_s),
    .wsel_o   (rom_wsel_s),
    .write_o  (rom_write_s)
  );

  // Next-state, next-access and status decode.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_s  = 1'b0;
    nstep_s = step_q;

    // An accepted access retires; a following one is loaded below if any.
    if (acc_s) begin
      req_d.valid = 1'b0;
    end else begin
      req_d.valid = req_q.valid;
    end

    case (state_q)
      ST_IDLE: begin
        if (desc_valid_i) begin
          desc_d  = desc_in_s;
          nstep_s = mac_update_i ? StepMacLo : StepSrcAddr;
          load_s  = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (acc_s && reg_rsp_i.error) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (acc_s && (step_q == StepReqClr)) begin
          nstep_s = StepPoll;
          load_s  = 1'b1;
          cnt_d   = '0;
          state_d = ST_POLL;
        end else if (acc_s) begin
          nstep_s = step_q + 4'd1;
          load_s  = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_POLL: begin
        if (acc_s && reg_rsp_i.error) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (acc_s && reg_rsp_i.rdata[0]) begin
          nstep_s = StepRspSet;
          load_s  = 1'b1;
          state_d = ST_ACK;
        end else if (acc_s && (cnt_inc_s == CntLimit)) begin
          cnt_d   = cnt_inc_s;
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (acc_s) begin
          cnt_d   = cnt_inc_s;
          nstep_s = StepPoll;
          load_s  = 1'b1;
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_ACK: begin
        if (acc_s && reg_rsp_i.error) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (acc_s && (step_q == StepRspClr)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (acc_s) begin
          nstep_s = step_q + 4'd1;
          load_s  = 1'b1;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = '0;
      end
    endcase

    if (load_s) begin
      step_d       = nstep_s;
      req_d.valid  = 1'b1;
      req_d.addr   = BaseAddr + {{(32-BlockAw){1'b0}}, rom_offset_s};
      req_d.write  = rom_write_s;
      req_d.wdata  = rom_write_s ? sel_wdata(rom_wsel_s, desc_src_s) : 32'h0000_0000;
      req_d.wstrb  = rom_write_s ? 4'hf : 4'h0;
    end else begin
      step_d = step_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops the bus request at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      desc_q  <= '0;
      req_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_eth_idma_cfg_seq.sv
// Bench for eth_idma_cfg_seq: register-port slave, access scoreboard and
// directed descriptor scenarios.
module tb_eth_idma_cfg_seq;
  import eth_idma_cfg_seq_pkg::*;
  import eth_idma_reg_pkg::*;

  localparam logic [31:0] Base = 32'h4000_0000;
  localparam int PT = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        desc_valid = 1'b0;
  logic        mac_update = 1'b0;
  logic [47:0] mac_addr = 48'h0;
  logic [31:0] src_addr = 32'h0, dst_addr = 32'h0, length = 32'h0;
  logic [2:0]  src_proto = 3'h0, dst_proto = 3'h0;
  logic        desc_ready, busy, done, err;
  reg_req_t    req;
  reg_rsp_t    rsp = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;

  acc_t exp_q[$];
  acc_t model_q[$];
  bit   model_err;
  int   model_lat;

  int   delay_max = 0, rv_on = 0, err_at = -1;
  int   acc_idx = 0, rd_idx = 0, wait_left = 0;
  bit   pending = 1'b0, held = 1'b0;
  reg_req_t held_req;

  eth_idma_cfg_seq #(.BaseAddr(Base), .PollTimeout(PT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .desc_valid_i (desc_valid),
    .desc_ready_o (desc_ready),
    .mac_update_i (mac_update),
    .mac_addr_i   (mac_addr),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .length_i     (length),
    .src_proto_i  (src_proto),
    .dst_proto_i  (dst_proto),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .reg_req_o    (req),
    .reg_rsp_i    (rsp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Slave and scoreboard: decide ready on the falling edge, check each access it will accept.
  always @(negedge clk) begin
    acc_t e;
    if (rst_n && req.valid) begin
      if (held) chk("req_stable", req, held_req);
      if (!pending) begin
        pending   = 1'b1;
        wait_left = (delay_max == 0) ? 0 : int'($urandom_range(0, delay_max));
      end
      rsp.ready = (wait_left == 0);
      rsp.error = rsp.ready && (acc_idx == err_at);
      rsp.rdata = (!req.write && rv_on != 0 && rd_idx + 1 >= rv_on) ? 32'hffff_ffff : 32'hffff_fffe;
      if (rsp.ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_access: got addr %0h write %0b, required none", req.addr, req.write);
        end else begin
          e = exp_q.pop_front();
          chk("acc_write", req.write, e.write);
          chk("acc_addr", req.addr, e.addr);
          chk("acc_wdata", req.wdata, e.wdata);
          chk("acc_wstrb", req.wstrb, e.wstrb);
        end
        acc_idx++;
        if (!req.write) rd_idx++;
        pending = 1'b0;
        held    = 1'b0;
      end else begin
        wait_left--;
        held     = 1'b1;
        held_req = req;
      end
    end else begin
      rsp     = '0;
      pending = 1'b0;
      held    = 1'b0;
    end
  end

  task automatic push_w(input logic [7:0] off, input logic [31:0] d);
    model_q.push_back('{write: 1'b1, addr: Base + {24'h0, off}, wdata: d, wstrb: 4'hf});
  endtask

  // Expected access list of one descriptor, from the register-programming recipe.
  task automatic build_model(input bit mu, input logic [47:0] mac, input logic [31:0] src,
                             input logic [31:0] dst, input logic [31:0] len,
                             input logic [2:0] sp, input logic [2:0] dp, input int rvo, input int ea);
    bit ok;
    int nrd;
    model_q.delete();
    if (mu) begin
      push_w(ETH_IDMA_MACLO_ADDR_OFFSET, mac[31:0]);
      push_w(ETH_IDMA_MACHI_MDIO_OFFSET, {16'h0, mac[47:32]});
    end
    push_w(ETH_IDMA_SRC_ADDR_OFFSET, src);
    push_w(ETH_IDMA_DST_ADDR_OFFSET, dst);
    push_w(ETH_IDMA_LENGTH_OFFSET, len);
    push_w(ETH_IDMA_SRC_PROTOCOL_OFFSET, {29'h0, sp});
    push_w(ETH_IDMA_DST_PROTOCOL_OFFSET, {29'h0, dp});
    push_w(ETH_IDMA_REQ_VALID_OFFSET, 32'h1);
    push_w(ETH_IDMA_REQ_VALID_OFFSET, 32'h0);
    ok  = (rvo > 0) && (rvo <= PT);
    nrd = ok ? rvo : PT;
    for (int i = 0; i < nrd; i++)
      model_q.push_back('{write: 1'b0, addr: Base + {24'h0, ETH_IDMA_RSP_VALID_OFFSET},
                          wdata: 32'h0, wstrb: 4'h0});
    if (ok) begin
      push_w(ETH_IDMA_RSP_READY_OFFSET, 32'h1);
      push_w(ETH_IDMA_RSP_READY_OFFSET, 32'h0);
    end
    model_err = !ok;
    if (ea >= 0 && ea < model_q.size()) begin
      model_q   = model_q[0:ea];
      model_err = 1'b1;
    end
    model_lat = model_q.size() + 1;
  endtask

  task automatic start_desc(input bit mu, input logic [47:0] mac, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] len,
                            input logic [2:0] sp, input logic [2:0] dp);
    int k;
    @(negedge clk);
    desc_valid = 1'b1;
    mac_update = mu;
    mac_addr   = mac;
    src_addr   = src;
    dst_addr   = dst;
    length     = len;
    src_proto  = sp;
    dst_proto  = dp;
    k = 0;
    while (!desc_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("desc_ready_idle", desc_ready, 1'b1);
    hs_cyc = cyc;
    @(negedge clk);
    desc_valid = 1'b0;
    mac_update = ~mu;
    mac_addr   = ~mac;
    src_addr   = ~src;
    dst_addr   = ~dst;
    length     = ~len;
    src_proto  = ~sp;
    dst_proto  = ~dp;
    chk("busy_started", busy, 1'b1);
    chk("desc_ready_busy", desc_ready, 1'b0);
  endtask

  task automatic run(input bit mu, input logic [47:0] mac, input logic [31:0] src,
                     input logic [31:0] dst, input logic [31:0] len,
                     input logic [2:0] sp, input logic [2:0] dp,
                     input int rvo, input int ea, input int dm, input int lit_lat, input int lit_cnt);
    bit seen;
    build_model(mu, mac, src, dst, len, sp, dp, rvo, ea);
    if (lit_lat >= 0) chk("model_latency", model_lat, lit_lat);
    if (lit_cnt >= 0) chk("model_count", model_q.size(), lit_cnt);
    exp_q     = model_q;
    rv_on     = rvo;
    err_at    = ea;
    delay_max = dm;
    acc_idx   = 0;
    rd_idx    = 0;
    start_desc(mu, mac, src, dst, len, sp, dp);
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      if (dm == 0) chk("done_latency", cyc - hs_cyc, model_lat);
      chk("err_flag", err, model_err);
      chk("desc_ready_in_done", desc_ready, 1'b0);
      chk("accesses_remaining", exp_q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("desc_ready_after_done", desc_ready, 1'b1);
      chk("busy_after_done", busy, 1'b0);
      chk("req_idle_after_done", req.valid, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_desc_ready", desc_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", req, 101'h0);
    rst_n = 1'b1;

    // Full sequence with MAC update, RSP_VALID on the third read.
    run(1'b1, 48'h2070_9800_1032, 32'h0, 32'h0, 32'h40, ProtoAxi, ProtoEth, 3, -1, 0, 15, 14);
    // No MAC update: first access is SRC_ADDR, completion on first read.
    run(1'b0, 48'h1111_2222_3333, 32'h8000_1000, 32'h8000_2000, 32'h100, ProtoEth, ProtoAxi, 1, -1, 0, 11, 10);
    // Slave inserting 0..5 wait states per access.
    run(1'b1, 48'hdead_beef_cafe, 32'h1234_5678, 32'h9abc_def0, 32'h7ff, 3'd5, 3'd0, 2, -1, 5, -1, 13);
    // Error response on the LENGTH write.
    run(1'b1, 48'h0a0b_0c0d_0e0f, 32'h100, 32'h200, 32'h300, 3'd0, 3'd5, 3, 4, 0, 6, 5);
    // Completion never reported: poll timeout.
    run(1'b0, 48'h0, 32'hc0de_0000, 32'hc0de_1000, 32'h20, 3'd5, 3'd5, 0, -1, 0, 12, 11);

    // Reset while polling.
    build_model(1'b0, 48'h0, 32'h10, 32'h20, 32'h30, 3'd0, 3'd5, 0, -1);
    exp_q     = model_q;
    rv_on     = 0;
    err_at    = -1;
    delay_max = 0;
    acc_idx   = 0;
    rd_idx    = 0;
    start_desc(1'b0, 48'h0, 32'h10, 32'h20, 32'h30, 3'd0, 3'd5);
    while (cyc - hs_cyc < 9) @(negedge clk);
    chk("poll_read_active", {req.valid, req.write}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", req.valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_desc_ready", desc_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // New descriptor accepted after reset release.
    run(1'b0, 48'h0, 32'h5555_0000, 32'h6666_0000, 32'h80, 3'd0, 3'd5, 2, -1, 0, 12, 11);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
